uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte FIFO sitting directly downstream of the UART receiver. Each single-cycle write strobe from the receiver pushes one received byte; the game/control logic pops bytes at its own pace. Provides full/empty/almost-full status, an occupancy count and a sticky overflow flag so that dropped bytes are detectable.

Parameters:
DATA_W, 8, width of each stored word (received byte)
ADDR_W, 4, pointer width; depth = 2**ADDR_W entries (16 by default)
AF_LEVEL, 12, almost_full asserts when level >= AF_LEVEL; legal range 1..2**ADDR_W

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
wr  input  1  push strobe; each cycle it is high is one write request
w_data  input  DATA_W  byte to push, sampled in the cycle wr is high
rd  input  1  pop strobe; each cycle it is high is one read request
r_data  output  DATA_W  read data (timing per Behaviour and Optional Feature)
empty  output  1  FIFO holds zero entries
full  output  1  FIFO holds 2**ADDR_W entries
almost_full  output  1  level >= AF_LEVEL
level  output  ADDR_W+1  current number of stored entries, 0..2**ADDR_W
overflow  output  1  sticky: a write was dropped because the FIFO was full
ovf_clr  input  1  clears overflow (single-cycle pulse)

Behaviour:
- One clock, synchronous active-high reset. Reset: write pointer = 0, read pointer = 0, level = 0, empty = 1, full = 0, almost_full = 0, overflow = 0, r_data = 0. Storage contents are not cleared. Reset asserted mid-stream discards all entries; an in-flight wr/rd in the reset cycle is ignored.
- Pointers are ADDR_W+1 bits (extra wrap bit). Memory address = low ADDR_W bits. full when the low bits are equal and the wrap bits differ; empty when all bits are equal. Pointers wrap naturally modulo 2**(ADDR_W+1).
- Valid write = wr & ~full; valid read = rd & ~empty. Each is evaluated on the pre-edge state.
- Valid write: mem[wptr] <= w_data, wptr += 1.
- Valid read: rptr += 1. In standard mode r_data <= mem[rptr], so data appears one cycle after rd; r_data holds its value until the next valid read.
- wr while full, without a simultaneous valid read: the byte is dropped, overflow <= 1, and no state change otherwise.
- wr and rd together while full: both are valid; the oldest entry is popped, the new byte is stored, level is unchanged, and overflow is not set.
- wr and rd together while empty: the write succeeds; the read is ignored (no bypass); level becomes 1.
- rd while empty: ignored; r_data, pointers and level are unchanged; no error flag.
- level, empty, full and almost_full are registered and consistent with the pointers after every edge. level changes by +1, -1 or 0 per cycle.
- overflow: set has priority over clear. If ovf_clr and a dropped write occur in the same cycle, overflow stays 1.
- No combinational path from wr/rd to any output in standard mode.

Optional Feature:
Macro: UART_RX_FIFO_FWFT_EN
- Defined (first-word-fall-through): r_data always shows mem[rptr[ADDR_W-1:0]] whenever empty = 0, with no read latency. rd acknowledges and pops the word; the next word is visible in the following cycle. r_data is don't-care while empty.
- Undefined: standard mode as specified above (registered r_data, 1-cycle read latency).
- Flags, level, overflow and all boundary rules are identical in both modes.

Decomposition:
- Shared package uart_pkg holds UART_DATA_W = 8, UART_FIFO_ADDR_W = 4, UART_FIFO_AF_LEVEL = 12, and the pointer typedef (ADDR_W+1 bits), so the receiver, this FIFO and the TX-side FIFO agree.
- One sub-module: uart_fifo_mem, a 2**ADDR_W x DATA_W register file with a synchronous write port and an asynchronous read port. It is reusable for the TX FIFO. Pointer, flag and overflow logic stays in uart_rx_fifo.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on consecutive cycles -> level = 3, empty = 0. Three pops -> r_data sequence 0x41, 0x42, 0x43 (1 cycle after each rd in standard mode; immediate in FWFT). Afterwards level = 0 and empty = 1.
- Push 16 bytes 0x00..0x0F -> full = 1, almost_full = 1 from level 12. 17th push of 0xFF -> dropped, overflow = 1, level = 16. Drain all 16 -> 0x00..0x0F in order; 0xFF never appears.
- At full, assert wr = 1 with 0xAA and rd = 1 in the same cycle -> level stays 16, overflow stays 0; after draining, the last byte read is 0xAA.
- Empty FIFO, assert wr (0x55) and rd together -> level = 1, r_data not updated. Next pop returns 0x55. rd on an empty FIFO -> no level change and r_data held.
- Wrap-around: 40 push/pop cycles of an incrementing byte pattern at level ≈ 3 -> output matches input order across pointer wrap. Assert ovf_clr together with a dropped write -> overflow remains 1; ovf_clr alone -> overflow = 0.
- Fill to 10 entries, assert reset for one cycle -> empty = 1, level = 0, full = 0, overflow = 0. A subsequent push/pop of 0x7E returns 0x7E.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and types.
// Holds the byte width, the FIFO pointer width, the almost-full threshold and
// the FIFO pointer type. The receiver, the RX FIFO and the TX FIFO all import
// this package so that they use the same widths.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_FIFO_ADDR_W   = 4;
    localparam int UART_FIFO_AF_LEVEL = 12;

    // One extra wrap bit above the address bits lets the FIFO tell full apart from empty.
    typedef logic [UART_FIFO_ADDR_W:0] uart_fifo_ptr_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register file with 2**ADDR_W words of DATA_W bits, used as FIFO storage.
// It has one synchronous write port and one asynchronous read port. The same
// module serves as storage for the RX FIFO and the TX FIFO.
// Ports:
//   clk     - write clock
//   we      - write enable; w_data is written to w_addr on the rising edge
//   w_addr  - write address
//   w_data  - write data
//   r_addr  - read address
//   r_data  - combinational read of mem[r_addr]
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset. The FIFO pointers decide which words are
    // valid, so clearing the array would add logic and buy nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO placed after the UART receiver.
// Every cycle with wr high pushes one byte, and every cycle with rd high pops
// one byte. The FIFO reports empty, full, almost_full, an occupancy level and
// a sticky overflow flag for writes that were dropped.
// Build option:
//   UART_RX_FIFO_FWFT_EN - if defined, r_data shows the head entry directly
//                          (first-word-fall-through). If undefined, r_data is
//                          registered and appears one cycle after rd.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   wr, w_data   - push strobe and byte
//   rd, r_data   - pop strobe and read data
//   empty, full, almost_full, level - registered occupancy status
//   overflow     - sticky dropped-write flag, cleared by an ovf_clr pulse
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W   = UART_DATA_W,
    parameter int ADDR_W   = UART_FIFO_ADDR_W,
    parameter int AF_LEVEL = UART_FIFO_AF_LEVEL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              ovf_clr
);

    // Local pointer type. It follows ADDR_W, so it stays correct when ADDR_W
    // is overridden; uart_fifo_ptr_t only matches the default width.
    typedef logic [ADDR_W:0] ptr_t;

    ptr_t              wptr, rptr;
    ptr_t              wptr_n, rptr_n, level_n;
    logic              wr_ok, rd_ok, drop;
    logic              empty_n, full_n, af_n;
    logic [DATA_W-1:0] mem_rdata;

    // If the FIFO is full it cannot also be empty, so an rd in that cycle is
    // a valid read. That read frees the slot the simultaneous write needs.
    assign wr_ok = wr & (~full | rd);
    assign rd_ok = rd & ~empty;
    assign drop  = wr & full & ~rd;

    // NOTE: every output of this block gets a value on every path, so the
    // tools build plain logic here and no latches.
    always_comb begin
        wptr_n  = wptr + ptr_t'(wr_ok);
        rptr_n  = rptr + ptr_t'(rd_ok);
        level_n = wptr_n - rptr_n;
        empty_n = (wptr_n == rptr_n);
        full_n  = (wptr_n[ADDR_W] != rptr_n[ADDR_W]) &&
                  (wptr_n[ADDR_W-1:0] == rptr_n[ADDR_W-1:0]);
        af_n    = (level_n >= ptr_t'(AF_LEVEL));
    end

    // NOTE: registers use non-blocking assignments. Every flop then samples
    // the values from before the edge, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wptr        <= wptr_n;
            rptr        <= rptr_n;
            level       <= level_n;
            empty       <= empty_n;
            full        <= full_n;
            almost_full <= af_n;
            // If a write is dropped in the same cycle as ovf_clr, the set wins.
            overflow    <= drop | (overflow & ~ovf_clr);
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .we     (wr_ok),
        .w_addr (wptr[ADDR_W-1:0]),
        .w_data (w_data),
        .r_addr (rptr[ADDR_W-1:0]),
        .r_data (mem_rdata)
    );

`ifdef UART_RX_FIFO_FWFT_EN
    // The head entry is shown directly. Its value is meaningless while empty.
    assign r_data = mem_rdata;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (rd_ok) begin
            r_data <= mem_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo.
// A reference queue models the FIFO contents. Each valid pop moves the
// expected byte into a scoreboard queue, and the test tasks compare it with
// the byte the DUT presents (one cycle later in standard mode, or the head
// value before the edge in FWFT mode).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr;
    logic [7:0] w_data;
    logic       rd;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] level;
    logic       overflow;
    logic       ovf_clr;

    int checks = 0;
    int passed = 0;

    logic [7:0] model_q[$];
    logic [7:0] exp_rd[$];
    logic       model_ovf;
    logic [7:0] model_rdata;
    logic [7:0] obs_rdata;
    logic [7:0] exp_byte;

    uart_rx_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .w_data      (w_data),
        .rd          (rd),
        .r_data      (r_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one clock cycle of stimulus and updates the reference model.
    // It is entered and left 1 time unit after a rising edge. obs_rdata holds
    // the byte the DUT delivered for a pop in this cycle.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic m_full, m_empty, w_ok, r_ok;
        wr      = w;
        w_data  = d;
        rd      = r;
        ovf_clr = c;
        m_full  = (model_q.size() == 16);
        m_empty = (model_q.size() == 0);
        w_ok    = w && (!m_full || r);
        r_ok    = r && !m_empty;
`ifdef UART_RX_FIFO_FWFT_EN
        #3;
        obs_rdata = r_data;
`endif
        @(posedge clk);
        if (r_ok) begin
            exp_rd.push_back(model_q.pop_front());
            model_rdata = exp_rd[$];
        end
        if (w_ok) model_q.push_back(d);
        if (w && m_full && !r) model_ovf = 1'b1;
        else if (c)            model_ovf = 1'b0;
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
        ovf_clr = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
        obs_rdata = r_data;
`endif
    endtask

    task automatic test_reset;
        reset = 1'b1; wr = 1'b0; rd = 1'b0; ovf_clr = 1'b0; w_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_q.delete(); exp_rd.delete();
        model_ovf = 1'b0; model_rdata = 8'h00;
        checks++; if (level !== 5'd0) $display("FAIL reset_level: got %0d want 0", level); else passed++;
        checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else passed++;
        checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passed++;
        checks++; if (almost_full !== 1'b0) $display("FAIL reset_af: got %b want 0", almost_full); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else passed++;
`ifndef UART_RX_FIFO_FWFT_EN
        checks++; if (r_data !== 8'h00) $display("FAIL reset_rdata: got %h want 00", r_data); else passed++;
`endif
    endtask

    task automatic test_basic;
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        cycle(1'b1, 8'h43, 1'b0, 1'b0);
        checks++; if (level !== 5'd3) $display("FAIL basic_level3: got %0d want 3", level); else passed++;
        checks++; if (empty !== 1'b0) $display("FAIL basic_empty0: got %b want 0", empty); else passed++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            exp_byte = exp_rd.pop_front();
            checks++; if (obs_rdata !== exp_byte) $display("FAIL basic_pop%0d: got %h want %h", i, obs_rdata, exp_byte); else passed++;
        end
        checks++; if (level !== 5'd0) $display("FAIL basic_level0: got %0d want 0", level); else passed++;
        checks++; if (empty !== 1'b1) $display("FAIL basic_empty1: got %b want 1", empty); else passed++;
    endtask

    task automatic test_full_overflow;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if (almost_full !== (model_q.size() >= 12))
                $display("FAIL fill_af_at_%0d: got %b want %b", model_q.size(), almost_full, model_q.size() >= 12);
            else passed++;
        end
        checks++; if (full !== 1'b1) $display("FAIL fill_full: got %b want 1", full); else passed++;
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (overflow !== model_ovf) $display("FAIL drop_ovf: got %b want %b", overflow, model_ovf); else passed++;
        checks++; if (level !== 5'd16) $display("FAIL drop_level: got %0d want 16", level); else passed++;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            exp_byte = exp_rd.pop_front();
            checks++; if (obs_rdata !== exp_byte) $display("FAIL drain_pop%0d: got %h want %h", i, obs_rdata, exp_byte); else passed++;
        end
        checks++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty); else passed++;
    endtask

    task automatic test_full_rw;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) $display("FAIL clr_ovf: got %b want 0", overflow); else passed++;
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        exp_byte = exp_rd.pop_front();
        checks++; if (obs_rdata !== exp_byte) $display("FAIL fullrw_pop: got %h want %h", obs_rdata, exp_byte); else passed++;
        checks++; if (level !== 5'd16) $display("FAIL fullrw_level: got %0d want 16", level); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL fullrw_ovf: got %b want 0", overflow); else passed++;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            exp_byte = exp_rd.pop_front();
            checks++; if (obs_rdata !== exp_byte) $display("FAIL fullrw_drain%0d: got %h want %h", i, obs_rdata, exp_byte); else passed++;
        end
        checks++; if (obs_rdata !== 8'hAA) $display("FAIL fullrw_last: got %h want aa", obs_rdata); else passed++;
    endtask

    task automatic test_empty_rw;
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        checks++; if (level !== 5'd1) $display("FAIL emptyrw_level: got %0d want 1", level); else passed++;
`ifndef UART_RX_FIFO_FWFT_EN
        checks++; if (r_data !== model_rdata) $display("FAIL emptyrw_rdata_held: got %h want %h", r_data, model_rdata); else passed++;
`endif
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        exp_byte = exp_rd.pop_front();
        checks++; if (obs_rdata !== exp_byte) $display("FAIL emptyrw_pop: got %h want %h", obs_rdata, exp_byte); else passed++;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if (level !== 5'd0) $display("FAIL underflow_level: got %0d want 0", level); else passed++;
        checks++; if (empty !== 1'b1) $display("FAIL underflow_empty: got %b want 1", empty); else passed++;
`ifndef UART_RX_FIFO_FWFT_EN
        checks++; if (r_data !== model_rdata) $display("FAIL underflow_rdata_held: got %h want %h", r_data, model_rdata); else passed++;
`endif
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 3; i < 43; i++) begin
            cycle(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            exp_byte = exp_rd.pop_front();
            checks++; if (obs_rdata !== exp_byte) $display("FAIL wrap_pop%0d: got %h want %h", i, obs_rdata, exp_byte); else passed++;
        end
        checks++; if (level !== 5'd3) $display("FAIL wrap_level: got %0d want 3", level); else passed++;
        for (int i = 0; i < 13; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_set_beats_clr: got %b want 1", overflow); else passed++;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_clr_alone: got %b want 0", overflow); else passed++;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            exp_byte = exp_rd.pop_front();
            checks++; if (obs_rdata !== exp_byte) $display("FAIL wrap_drain%0d: got %h want %h", i, obs_rdata, exp_byte); else passed++;
        end
    endtask

    task automatic test_reset_midstream;
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEF, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        exp_rd.delete();
        checks++; if (level !== 5'd10) $display("FAIL pre_reset_level: got %0d want 10", level); else passed++;
        // A reset with a write in flight: the write is discarded too.
        reset = 1'b1; wr = 1'b1; w_data = 8'h99;
        @(posedge clk);
        #1;
        reset = 1'b0; wr = 1'b0;
        model_q.delete(); model_ovf = 1'b0; model_rdata = 8'h00;
        checks++; if (empty !== 1'b1) $display("FAIL mid_reset_empty: got %b want 1", empty); else passed++;
        checks++; if (level !== 5'd0) $display("FAIL mid_reset_level: got %0d want 0", level); else passed++;
        checks++; if (full !== 1'b0) $display("FAIL mid_reset_full: got %b want 0", full); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL mid_reset_ovf: got %b want 0", overflow); else passed++;
        cycle(1'b1, 8'h7E, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        exp_byte = exp_rd.pop_front();
        checks++; if (obs_rdata !== exp_byte) $display("FAIL post_reset_pop: got %h want %h", obs_rdata, exp_byte); else passed++;
        checks++; if (empty !== 1'b1) $display("FAIL post_reset_empty: got %b want 1", empty); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overflow();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
